// File: rtl/i2c_slave.sv
// I2C target for one 7-bit address; write bytes out as strobes, read bytes fetched via tx_req/tx_stb.
// Latency: 3 clk from pad to decision; backpressure: SCL is stretched while waiting for read data.
module i2c_slave #(
    parameter logic [6:0] ADDR       = 7'h50,
    parameter int         HOLD_CYC   = 4,
    parameter bit         STRETCH_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_out,
    output logic       sda_out,
    output logic [7:0] rx_dat,
    output logic       rx_stb,
    output logic       tx_req,
    input  logic [7:0] tx_dat,
    input  logic       tx_stb,
    input  logic       tx_nak,
    output logic       busy,
    output logic       rd_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_AACK, S_WRX, S_WACK, S_TXW, S_RTX, S_RACK
    } state_t;

    localparam logic [3:0] HOLD = 4'(HOLD_CYC);

    state_t     state, state_nx;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_q, sda_q;
    logic [2:0] bit_cnt, bit_nx;
    logic [7:0] sr, sr_nx;
    logic       ph, ph_nx;
    logic       rw, rw_nx;
    logic       nak_q, nak_nx;
    logic       busy_nx, rx_stb_nx, tx_req_nx, rd_done_nx;
    logic [7:0] rx_dat_nx;
    logic       drv_val, drv_nx;
    logic [3:0] hold_cnt, hold_nx;
    logic       sda_nx, scl_nx;
    logic       rel_pend, rel_nx;

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_q    <= scl_sync[1];
            sda_q    <= sda_sync[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            bit_cnt  <= 3'd7;
            sr       <= 8'h00;
            ph       <= 1'b0;
            rw       <= 1'b0;
            nak_q    <= 1'b0;
            busy     <= 1'b0;
            rx_dat   <= 8'h00;
            rx_stb   <= 1'b0;
            tx_req   <= 1'b0;
            rd_done  <= 1'b0;
            drv_val  <= 1'b1;
            hold_cnt <= 4'd0;
            sda_out  <= 1'b1;
            scl_out  <= 1'b1;
            rel_pend <= 1'b0;
        end else begin
            state    <= state_nx;
            bit_cnt  <= bit_nx;
            sr       <= sr_nx;
            ph       <= ph_nx;
            rw       <= rw_nx;
            nak_q    <= nak_nx;
            busy     <= busy_nx;
            rx_dat   <= rx_dat_nx;
            rx_stb   <= rx_stb_nx;
            tx_req   <= tx_req_nx;
            rd_done  <= rd_done_nx;
            drv_val  <= drv_nx;
            hold_cnt <= hold_nx;
            sda_out  <= sda_nx;
            scl_out  <= scl_nx;
            rel_pend <= rel_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        bit_nx     = bit_cnt;
        sr_nx      = sr;
        ph_nx      = ph;
        rw_nx      = rw;
        nak_nx     = nak_q;
        busy_nx    = busy;
        rx_dat_nx  = rx_dat;
        rx_stb_nx  = 1'b0;
        tx_req_nx  = 1'b0;
        rd_done_nx = 1'b0;
        drv_nx     = drv_val;
        hold_nx    = (hold_cnt != 4'd0) ? hold_cnt - 4'd1 : 4'd0;
        sda_nx     = (hold_cnt == 4'd1) ? drv_val : sda_out;
        scl_nx     = rel_pend ? 1'b1 : scl_out;
        // Stretch ends one cycle after the first read bit reaches the pad.
        rel_nx     = (hold_cnt == 4'd1) && (state == S_RTX) && !scl_out;

        if (stop_det) begin
            state_nx = S_IDLE;
            busy_nx  = 1'b0;
            sda_nx   = 1'b1;
            scl_nx   = 1'b1;
            drv_nx   = 1'b1;
            hold_nx  = 4'd0;
            rel_nx   = 1'b0;
        end else if (start_det) begin
            state_nx = S_ADDR;
            bit_nx   = 3'd7;
            ph_nx    = 1'b0;
            sda_nx   = 1'b1;
            scl_nx   = 1'b1;
            drv_nx   = 1'b1;
            hold_nx  = 4'd0;
            rel_nx   = 1'b0;
        end else begin
            case (state)
                S_IDLE: ;
                S_ADDR: if (scl_rise) begin
                    sr_nx  = {sr[6:0], sda_s};
                    bit_nx = bit_cnt - 3'd1;
                    if (bit_cnt == 3'd0) begin
                        if (sr[6:0] == ADDR) begin
                            state_nx = S_AACK;
                            rw_nx    = sda_s;
                            ph_nx    = 1'b0;
                        end else begin
                            state_nx = S_IDLE;
                            busy_nx  = 1'b0;
                        end
                    end
                end
                // ph=0: fall ending bit 8 (start ACK); ph=1: fall ending the ACK.
                S_AACK: if (scl_fall) begin
                    hold_nx = HOLD;
                    if (!ph) begin
                        drv_nx  = 1'b0;
                        ph_nx   = 1'b1;
                        busy_nx = 1'b1;
                    end else begin
                        drv_nx = 1'b1;
                        ph_nx  = 1'b0;
                        if (rw) begin
                            tx_req_nx = 1'b1;
                            state_nx  = S_TXW;
                            scl_nx    = !STRETCH_EN;
                        end else begin
                            state_nx = S_WRX;
                        end
                    end
                end
                S_WRX: if (scl_rise) begin
                    sr_nx  = {sr[6:0], sda_s};
                    bit_nx = bit_cnt - 3'd1;
                    if (bit_cnt == 3'd0) begin
                        rx_dat_nx = {sr[6:0], sda_s};
                        rx_stb_nx = 1'b1;
                        nak_nx    = tx_nak;
                        state_nx  = S_WACK;
                        ph_nx     = 1'b0;
                    end
                end
                S_WACK: if (scl_fall) begin
                    hold_nx = HOLD;
                    if (!ph) begin
                        drv_nx = nak_q;
                        ph_nx  = 1'b1;
                    end else begin
                        drv_nx   = 1'b1;
                        ph_nx    = 1'b0;
                        state_nx = S_WRX;
                    end
                end
                S_TXW: begin
                    if (tx_stb && (STRETCH_EN || !scl_s)) begin
                        sr_nx    = tx_dat;
                        drv_nx   = tx_dat[7];
                        hold_nx  = HOLD;
                        state_nx = S_RTX;
                        bit_nx   = 3'd7;
                        ph_nx    = 1'b0;
                    end else if (!STRETCH_EN && scl_rise) begin
                        // No data in time and no stretching: bit 7 already went out released.
                        sr_nx    = 8'hff;
                        state_nx = S_RTX;
                        bit_nx   = 3'd6;
                        ph_nx    = 1'b0;
                    end
                end
                // ph marks that the 8th bit has been clocked.
                S_RTX: begin
                    if (scl_rise) begin
                        bit_nx = bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) ph_nx = 1'b1;
                        if (sda_out && !sda_s) begin
                            state_nx = S_IDLE;
                            drv_nx   = 1'b1;
                            sda_nx   = 1'b1;
                            scl_nx   = 1'b1;
                            hold_nx  = 4'd0;
                            rel_nx   = 1'b0;
                        end
                    end else if (scl_fall) begin
                        hold_nx = HOLD;
                        if (ph) begin
                            drv_nx   = 1'b1;
                            ph_nx    = 1'b0;
                            state_nx = S_RACK;
                        end else begin
                            sr_nx  = {sr[6:0], 1'b0};
                            drv_nx = sr[6];
                        end
                    end
                end
                S_RACK: begin
                    if (scl_rise && sda_s) begin
                        rd_done_nx = 1'b1;
                        state_nx   = S_IDLE;
                    end else if (scl_fall) begin
                        tx_req_nx = 1'b1;
                        state_nx  = S_TXW;
                        scl_nx    = !STRETCH_EN;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-level I2C master model, delayed read-data responder, rx/read scoreboards.
module tb_i2c_slave;
    localparam int T = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       scl_out, sda_out, scl_line, sda_line;
    logic [7:0] rx_dat, tx_dat;
    logic       rx_stb, tx_req, tx_stb, tx_nak, busy, rd_done;

    int total = 0, bad = 0;
    int rx_cnt = 0, tx_req_cnt = 0, rd_done_cnt = 0;
    int stretch_run = 0, last_stretch = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] rd_src[$];
    logic [7:0] exp_rd[$];
    logic [7:0] e_rx;

    always #5 clk = ~clk;

    assign scl_line = scl_m & scl_out;
    assign sda_line = sda_m & sda_out;

    i2c_slave #(.ADDR(7'h50), .HOLD_CYC(4), .STRETCH_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_line), .sda_in(sda_line),
        .scl_out(scl_out), .sda_out(sda_out), .rx_dat(rx_dat), .rx_stb(rx_stb),
        .tx_req(tx_req), .tx_dat(tx_dat), .tx_stb(tx_stb), .tx_nak(tx_nak),
        .busy(busy), .rd_done(rd_done)
    );

    // Received-byte scoreboard and event counters.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_stb) begin
                rx_cnt++;
                total++;
                if (exp_rx.size() == 0) begin
                    bad++;
                    $display("FAIL rx_unexpected got=%h want=none", rx_dat);
                end else begin
                    e_rx = exp_rx.pop_front();
                    if (rx_dat !== e_rx) begin
                        bad++;
                        $display("FAIL rx_dat got=%h want=%h", rx_dat, e_rx);
                    end
                end
            end
            if (tx_req) tx_req_cnt++;
            if (rd_done) rd_done_cnt++;
            if (scl_out === 1'b0) stretch_run++;
            else if (stretch_run != 0) begin
                last_stretch = stretch_run;
                stretch_run = 0;
            end
        end
    end

    // Local read-data source: answers every tx_req 20 cycles late.
    initial begin
        tx_stb = 1'b0;
        tx_dat = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_req === 1'b1) begin
                repeat (20) @(negedge clk);
                tx_dat = (rd_src.size() != 0) ? rd_src.pop_front() : 8'h00;
                exp_rd.push_back(tx_dat);
                tx_stb = 1'b1;
                @(negedge clk);
                tx_stb = 1'b0;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_bit(input logic b, output logic r);
        int n;
        sda_m = b;
        wait_clk(T);
        scl_m = 1'b1;
        n = 0;
        while (scl_line !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            total++;
            bad++;
            $display("FAIL scl_release got=low want=high");
        end
        wait_clk(T);
        r = sda_line;
        scl_m = 1'b0;
        wait_clk(T);
    endtask

    task automatic m_start;
        sda_m = 1'b1;
        wait_clk(T);
        scl_m = 1'b1;
        wait_clk(T);
        sda_m = 1'b0;
        wait_clk(T);
        scl_m = 1'b0;
        wait_clk(T);
    endtask

    task automatic m_stop;
        sda_m = 1'b0;
        wait_clk(T);
        scl_m = 1'b1;
        wait_clk(T);
        sda_m = 1'b1;
        wait_clk(T);
    endtask

    task automatic m_wr_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) m_bit(d[i], r);
        m_bit(1'b1, ack);
    endtask

    task automatic m_rd_byte(input logic ackb, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, r);
            d[i] = r;
        end
        m_bit(ackb, r);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tx_nak = 1'b0;
        wait_clk(5);
        total++; if (scl_out !== 1'b1) begin bad++; $display("FAIL reset_scl_out got=%b want=1", scl_out); end
        total++; if (sda_out !== 1'b1) begin bad++; $display("FAIL reset_sda_out got=%b want=1", sda_out); end
        total++; if (rx_dat !== 8'h00) begin bad++; $display("FAIL reset_rx_dat got=%h want=00", rx_dat); end
        total++; if (rx_stb !== 1'b0) begin bad++; $display("FAIL reset_rx_stb got=%b want=0", rx_stb); end
        total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL reset_tx_req got=%b want=0", tx_req); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (rd_done !== 1'b0) begin bad++; $display("FAIL reset_rd_done got=%b want=0", rd_done); end
        rst = 1'b0;
        wait_clk(5);
    endtask

    task automatic test_write;
        logic ack;
        int r0;
        r0 = rx_cnt;
        m_start;
        m_wr_byte({7'h50, 1'b0}, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL wr_addr_ack got=%b want=0", ack); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b want=1", busy); end
        exp_rx.push_back(8'hA5);
        m_wr_byte(8'hA5, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL wr_byte1_ack got=%b want=0", ack); end
        exp_rx.push_back(8'h3C);
        m_wr_byte(8'h3C, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL wr_byte2_ack got=%b want=0", ack); end
        m_stop;
        wait_clk(10);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_after_stop got=%b want=0", busy); end
        total++; if (rx_cnt - r0 != 2) begin bad++; $display("FAIL wr_rx_count got=%0d want=2", rx_cnt - r0); end
    endtask

    task automatic test_bad_addr;
        logic ack;
        int r0;
        r0 = rx_cnt;
        m_start;
        m_wr_byte({7'h51, 1'b0}, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL badaddr_ack got=%b want=1", ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL badaddr_busy got=%b want=0", busy); end
        m_wr_byte(8'h12, ack);
        m_stop;
        wait_clk(10);
        total++; if (rx_cnt != r0) begin bad++; $display("FAIL badaddr_rx_count got=%0d want=%0d", rx_cnt, r0); end
    endtask

    task automatic test_read;
        logic ack;
        logic [7:0] d, e;
        int d0, q0;
        d0 = rd_done_cnt;
        q0 = tx_req_cnt;
        rd_src.push_back(8'h96);
        rd_src.push_back(8'h0F);
        m_start;
        m_wr_byte({7'h50, 1'b1}, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rd_addr_ack got=%b want=0", ack); end
        for (int k = 0; k < 2; k++) begin
            last_stretch = 0;
            m_rd_byte(k == 1, d);
            e = (exp_rd.size() != 0) ? exp_rd.pop_front() : 8'hxx;
            total++; if (d !== e) begin bad++; $display("FAIL rd_byte%0d got=%h want=%h", k, d, e); end
            total++;
            if (last_stretch < 18 || last_stretch > 40) begin
                bad++;
                $display("FAIL rd_stretch%0d got=%0d want=18..40", k, last_stretch);
            end
        end
        m_stop;
        wait_clk(10);
        total++; if (rd_done_cnt - d0 != 1) begin bad++; $display("FAIL rd_done_count got=%0d want=1", rd_done_cnt - d0); end
        total++; if (tx_req_cnt - q0 != 2) begin bad++; $display("FAIL rd_tx_req_count got=%0d want=2", tx_req_cnt - q0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_busy_after_stop got=%b want=0", busy); end
    endtask

    task automatic test_nak;
        logic ack;
        int r0;
        r0 = rx_cnt;
        tx_nak = 1'b1;
        m_start;
        m_wr_byte({7'h50, 1'b0}, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL nak_addr_ack got=%b want=0", ack); end
        exp_rx.push_back(8'h11);
        m_wr_byte(8'h11, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL nak_data_bit got=%b want=1", ack); end
        tx_nak = 1'b0;
        m_stop;
        wait_clk(10);
        total++; if (rx_cnt - r0 != 1) begin bad++; $display("FAIL nak_rx_count got=%0d want=1", rx_cnt - r0); end
    endtask

    task automatic test_partial_restart;
        logic ack, r;
        logic [7:0] d, e;
        int r0, q0;
        logic [3:0] part;
        part = 4'b1011;
        r0 = rx_cnt;
        q0 = tx_req_cnt;
        rd_src.push_back(8'h5A);
        m_start;
        m_wr_byte({7'h50, 1'b0}, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rs_wr_addr_ack got=%b want=0", ack); end
        for (int i = 3; i >= 0; i--) m_bit(part[i], r);
        m_start;
        m_wr_byte({7'h50, 1'b1}, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rs_rd_addr_ack got=%b want=0", ack); end
        m_rd_byte(1'b1, d);
        e = (exp_rd.size() != 0) ? exp_rd.pop_front() : 8'hxx;
        total++; if (d !== e) begin bad++; $display("FAIL rs_rd_byte got=%h want=%h", d, e); end
        total++; if (tx_req_cnt - q0 != 1) begin bad++; $display("FAIL rs_tx_req_count got=%0d want=1", tx_req_cnt - q0); end
        m_stop;
        wait_clk(10);
        total++; if (rx_cnt != r0) begin bad++; $display("FAIL rs_partial_rx got=%0d want=%0d", rx_cnt, r0); end
    endtask

    task automatic test_reset_mid_ack;
        logic ack, r;
        logic [7:0] a;
        int n;
        a = {7'h50, 1'b0};
        m_start;
        for (int i = 7; i >= 0; i--) m_bit(a[i], r);
        n = 0;
        while (sda_out !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++; if (sda_out !== 1'b0) begin bad++; $display("FAIL rst_ack_driven got=%b want=0", sda_out); end
        #2 rst = 1'b1;
        #1;
        total++; if (sda_out !== 1'b1) begin bad++; $display("FAIL rst_sda_release got=%b want=1", sda_out); end
        total++; if (scl_out !== 1'b1) begin bad++; $display("FAIL rst_scl_release got=%b want=1", scl_out); end
        wait_clk(3);
        rst = 1'b0;
        wait_clk(5);
        m_stop;
        m_start;
        m_wr_byte({7'h50, 1'b0}, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL post_rst_addr_ack got=%b want=0", ack); end
        exp_rx.push_back(8'h77);
        m_wr_byte(8'h77, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL post_rst_data_ack got=%b want=0", ack); end
        m_stop;
        wait_clk(10);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b want=0", busy); end
    endtask

    initial begin
        tx_nak = 1'b0;
        test_reset;
        test_write;
        test_bad_addr;
        test_read;
        test_nak;
        test_partial_restart;
        test_reset_mid_ack;
        wait_clk(20);
        total++; if (exp_rx.size() != 0) begin bad++; $display("FAIL rx_left got=%0d want=0", exp_rx.size()); end
        total++; if (exp_rd.size() != 0) begin bad++; $display("FAIL rd_left got=%0d want=0", exp_rd.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
